// File: rtl/crossbar_pkg.sv
// rtl/crossbar_pkg.sv - shared types and constants for the 4x4 crossbar arbiters
package crossbar_pkg;

    localparam int DEFAULT_QTY_OF_DEVICES = 4;

    localparam logic CMD_READ  = 1'b0;
    localparam logic CMD_WRITE = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        RESP  = 2'd2
    } arb_state_t;

    function automatic int wrap_inc(input int idx, input int n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// rtl/rr_priority_picker.sv - combinational round-robin picker starting the search at ptr
module rr_priority_picker
    import crossbar_pkg::*;
#(
    parameter int N = DEFAULT_QTY_OF_DEVICES
) (
    input  logic [N-1:0]         i_req,
    input  logic [$clog2(N)-1:0] i_ptr,
    output logic [$clog2(N)-1:0] o_winner,
    output logic                 o_any_req
);

    localparam int IW = $clog2(N);

    logic [2*N-1:0] w_dbl;
    logic [2*N-1:0] w_masked;
    logic           w_found;

    // Upper copy stays unmasked so the search wraps past N-1 back to index 0.
    always_comb begin
        w_dbl    = {i_req, i_req};
        w_masked = '0;
        w_found  = 1'b0;
        o_winner = '0;
        for (int i = 0; i < 2 * N; i++) begin
            w_masked[i] = w_dbl[i] & ((i >= N) || (i >= int'(i_ptr)));
        end
        for (int i = 0; i < 2 * N; i++) begin
            if (!w_found && w_masked[i]) begin
                w_found  = 1'b1;
                o_winner = (i >= N) ? IW'(i - N) : IW'(i);
            end
        end
    end

    assign o_any_req = |i_req;

endmodule

// File: rtl/slave_session_arbiter.sv
// rtl/slave_session_arbiter.sv - per-slave round-robin arbiter holding a grant for a whole session
module slave_session_arbiter
    import crossbar_pkg::*;
#(
    parameter int QTY_OF_DEVICES = DEFAULT_QTY_OF_DEVICES,
    parameter int TIMEOUT        = 256
) (
    input  logic                              i_clk,
    input  logic                              i_rst_n,
    input  logic [QTY_OF_DEVICES-1:0]         i_req,
    input  logic [QTY_OF_DEVICES-1:0]         i_cmd,
    input  logic                              i_slave_ack,
    input  logic                              i_slave_resp,
    output logic [QTY_OF_DEVICES-1:0]         o_grant,
    output logic [$clog2(QTY_OF_DEVICES)-1:0] o_owner,
    output logic                              o_busy,
    output logic                              o_session_is_finished,
    output logic                              o_timeout_err
);

    localparam int IW   = $clog2(QTY_OF_DEVICES);
    localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT > 0) ? WD_W'(TIMEOUT - 1) : '0;
    localparam logic [WD_W-1:0] WD_MAX  = '1;
    localparam logic [QTY_OF_DEVICES-1:0] ONE = QTY_OF_DEVICES'(1);

    arb_state_t                r_state;
    arb_state_t                w_state_next;
    logic [QTY_OF_DEVICES-1:0] r_grant;
    logic [IW-1:0]             r_owner;
    logic [IW-1:0]             r_ptr;
    logic                      r_cmd_q;
    logic [WD_W-1:0]           r_wd_cnt;
    logic                      r_finished;
    logic                      r_timeout_err;

    logic [IW-1:0]             w_winner;
    logic                      w_any_req;
    logic                      w_wd_hit;
    logic                      w_end;
    logic                      w_timeout;

    rr_priority_picker #(
        .N(QTY_OF_DEVICES)
    ) u_picker (
        .i_req     (i_req),
        .i_ptr     (r_ptr),
        .o_winner  (w_winner),
        .o_any_req (w_any_req)
    );

    assign w_wd_hit = (TIMEOUT != 0) && (r_wd_cnt == WD_LAST);

    // Priority inside a session: ack/resp, then owner abort, then watchdog.
    always_comb begin
        w_state_next = r_state;
        w_end        = 1'b0;
        w_timeout    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_any_req) w_state_next = GRANT;
            end
            GRANT: begin
                if (i_slave_ack) begin
                    if (r_cmd_q == CMD_READ) begin
                        w_state_next = RESP;
                    end else begin
                        w_state_next = IDLE;
                        w_end        = (r_cmd_q == CMD_WRITE);
                    end
                end else if (!i_req[r_owner]) begin
                    w_state_next = IDLE;
                    w_end        = 1'b1;
                end else if (w_wd_hit) begin
                    w_state_next = IDLE;
                    w_end        = 1'b1;
                    w_timeout    = 1'b1;
                end
            end
            RESP: begin
                if (i_slave_resp) begin
                    w_state_next = IDLE;
                    w_end        = 1'b1;
                end else if (w_wd_hit) begin
                    w_state_next = IDLE;
                    w_end        = 1'b1;
                    w_timeout    = 1'b1;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state       <= IDLE;
            r_grant       <= '0;
            r_owner       <= '0;
            r_ptr         <= '0;
            r_cmd_q       <= CMD_READ;
            r_wd_cnt      <= '0;
            r_finished    <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_finished    <= w_end;
            r_timeout_err <= w_timeout;

            if (w_state_next != r_state) begin
                r_wd_cnt <= '0;
            end else if (r_state != IDLE && r_wd_cnt != WD_MAX) begin
                r_wd_cnt <= r_wd_cnt + 1'b1;
            end

            if (r_state == IDLE && w_any_req) begin
                r_grant <= ONE << w_winner;
                r_owner <= w_winner;
                r_cmd_q <= i_cmd[w_winner];
            end

            // Last owner drops to lowest priority for the next arbitration.
            if (w_end) begin
                r_grant <= '0;
                r_ptr   <= IW'(wrap_inc(int'(r_owner), QTY_OF_DEVICES));
            end
        end
    end

    assign o_grant               = r_grant;
    assign o_owner               = r_owner;
    assign o_busy                = |r_grant;
    assign o_session_is_finished = r_finished;
    assign o_timeout_err         = r_timeout_err;

endmodule

// File: tb/tb_slave_session_arbiter.sv
// tb/tb_slave_session_arbiter.sv - directed self-checking bench for slave_session_arbiter
module tb_slave_session_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] cmd;
    logic       ack;
    logic       resp;
    logic [3:0] grant;
    logic [1:0] owner;
    logic       busy;
    logic       fin;
    logic       to_err;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    slave_session_arbiter #(
        .QTY_OF_DEVICES(4),
        .TIMEOUT       (8)
    ) dut (
        .i_clk                 (clk),
        .i_rst_n               (rst_n),
        .i_req                 (req),
        .i_cmd                 (cmd),
        .i_slave_ack           (ack),
        .i_slave_resp          (resp),
        .o_grant               (grant),
        .o_owner               (owner),
        .o_busy                (busy),
        .o_session_is_finished (fin),
        .o_timeout_err         (to_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [3:0] g, input logic f, input logic t);
        check({tag, "_grant"}, 32'(grant), 32'(g));
        check({tag, "_busy"}, 32'(busy), 32'(|g));
        check({tag, "_fin"}, 32'(fin), 32'(f));
        check({tag, "_to"}, 32'(to_err), 32'(t));
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 4'b1111;
        cmd   = 4'b0000;
        ack   = 1'b0;
        resp  = 1'b0;

        // reset held two edges with all requests up
        tick();
        chk_out("rst1", 4'b0000, 1'b0, 1'b0);
        tick();
        chk_out("rst2", 4'b0000, 1'b0, 1'b0);
        check("rst_owner", 32'(owner), 32'd0);

        // write rotation with ack held high
        rst_n = 1'b1;
        cmd   = 4'b1111;
        ack   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_out($sformatf("rot%0d", i), 4'b0001 << (i % 4), 1'b0, 1'b0);
            check($sformatf("rot%0d_owner", i), 32'(owner), 32'(i % 4));
            if (i == 4) req = 4'b0000;
            tick();
            chk_out($sformatf("rot%0d_gap", i), 4'b0000, 1'b1, 1'b0);
        end
        ack = 1'b0;

        // read session on master 2: ack 3 cycles after grant, resp 5 after ack
        req = 4'b0100;
        cmd = 4'b0000;
        tick();
        chk_out("rd_g0", 4'b0100, 1'b0, 1'b0);
        check("rd_owner", 32'(owner), 32'd2);
        for (int i = 1; i < 3; i++) begin
            tick();
            chk_out($sformatf("rd_g%0d", i), 4'b0100, 1'b0, 1'b0);
        end
        ack = 1'b1;
        tick();
        chk_out("rd_ack", 4'b0100, 1'b0, 1'b0);
        ack = 1'b0;
        cmd = 4'b1111;
        for (int i = 1; i < 5; i++) begin
            tick();
            chk_out($sformatf("rd_r%0d", i), 4'b0100, 1'b0, 1'b0);
        end
        resp = 1'b1;
        tick();
        chk_out("rd_fin", 4'b0000, 1'b1, 1'b0);
        check("rd_owner_keep", 32'(owner), 32'd2);
        resp = 1'b0;

        // ptr must now be 3: master 3 beats 0 and 1
        req = 4'b1011;
        ack = 1'b1;
        tick();
        chk_out("ptr3", 4'b1000, 1'b0, 1'b0);
        req = 4'b1001;
        tick();
        chk_out("ptr3_fin", 4'b0000, 1'b1, 1'b0);
        tick();
        chk_out("wrap_m0", 4'b0001, 1'b0, 1'b0);
        tick();
        chk_out("wrap_m0_fin", 4'b0000, 1'b1, 1'b0);
        tick();
        chk_out("wrap_m3", 4'b1000, 1'b0, 1'b0);
        req = 4'b0000;
        tick();
        chk_out("wrap_m3_fin", 4'b0000, 1'b1, 1'b0);
        ack = 1'b0;

        // watchdog: read on master 1, resp never comes
        req = 4'b0010;
        cmd = 4'b0000;
        tick();
        chk_out("wd_g", 4'b0010, 1'b0, 1'b0);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick();
            chk_out($sformatf("wd_r%0d", i), 4'b0010, 1'b0, 1'b0);
        end
        tick();
        req = 4'b0000;
        chk_out("wd_fire", 4'b0000, 1'b1, 1'b1);
        tick();
        chk_out("wd_after", 4'b0000, 1'b0, 1'b0);

        // resp lands on the very cycle the watchdog would fire: resp wins
        req = 4'b0010;
        tick();
        chk_out("wd2_g", 4'b0010, 1'b0, 1'b0);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick();
            chk_out($sformatf("wd2_r%0d", i), 4'b0010, 1'b0, 1'b0);
        end
        resp = 1'b1;
        tick();
        chk_out("wd2_fin", 4'b0000, 1'b1, 1'b0);
        resp = 1'b0;
        req  = 4'b0000;

        // abort: owner drops req in GRANT before ack
        req = 4'b0100;
        tick();
        chk_out("ab_g", 4'b0100, 1'b0, 1'b0);
        req = 4'b0000;
        tick();
        chk_out("ab_fin", 4'b0000, 1'b1, 1'b0);
        tick();
        chk_out("ab_after", 4'b0000, 1'b0, 1'b0);

        // reset during RESP: grant drops, no finish pulse, ptr back to 0
        req = 4'b1000;
        tick();
        chk_out("mr_g", 4'b1000, 1'b0, 1'b0);
        check("mr_owner", 32'(owner), 32'd3);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        tick();
        chk_out("mr_resp", 4'b1000, 1'b0, 1'b0);
        rst_n = 1'b0;
        tick();
        chk_out("mr_rst", 4'b0000, 1'b0, 1'b0);
        check("mr_owner_rst", 32'(owner), 32'd0);
        rst_n = 1'b1;
        req   = 4'b0000;
        tick();
        chk_out("mr_idle", 4'b0000, 1'b0, 1'b0);
        req = 4'b1111;
        cmd = 4'b1111;
        tick();
        chk_out("mr_ptr0", 4'b0001, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/slave_session_arbiter.md
# slave_session_arbiter

Per-slave arbiter with session tracking for the 4x4 crossbar. One instance sits in front of each slave port. It picks one requesting master by round robin and holds that grant for a whole transaction: request, slave ack, and slave response for reads. It then releases the grant with a one-cycle `session_is_finished` pulse that the commutation logic uses to tear down the path. A response watchdog keeps a stalled slave from holding the port forever.

## Interface
- `QTY_OF_DEVICES`, 4: number of masters competing for this slave; must be at least 2.
- `TIMEOUT`, 256: cycles allowed in GRANT or RESP before forced release; 0 disables the watchdog.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; synchronous and active-low.
- `req`  in  QTY_OF_DEVICES  per-master request already decoded for this slave; bit i = master i.
- `cmd`  in  QTY_OF_DEVICES  per-master command; 1 = write, 0 = read.
- `slave_ack`  in  1  slave accepted the address phase.
- `slave_resp`  in  1  slave returned read data.
- `grant`  out  QTY_OF_DEVICES  one-hot owner of the slave, or all zero.
- `owner`  out  $clog2(QTY_OF_DEVICES)  index of the current or last owner.
- `busy`  out  1  session in progress; equals `|grant`.
- `session_is_finished`  out  1  one-cycle pulse when a session ends.
- `timeout_err`  out  1  one-cycle pulse when a session ends by watchdog.

## Operation
- States: IDLE, GRANT, RESP.
- **IDLE**
  - If `req != 0`, pick a winner with the round-robin picker. Search starts at `ptr`, wraps modulo `QTY_OF_DEVICES`, first set bit wins.
  - Register `grant` = onehot(winner) and `owner` = winner.
  - Latch `cmd[winner]` into `cmd_q` and go to GRANT.
- **GRANT**
  - If `slave_ack` and `cmd_q == 1` (write): go to IDLE.
  - If `slave_ack` and `cmd_q == 0` (read): go to RESP.
  - If the owner drops `req` before `slave_ack`: abort to IDLE. This is a protocol violation, but it must not hang.
  - `slave_ack` has priority over an abort seen in the same cycle.
- **RESP**
  - On `slave_resp`, go to IDLE.
  - `req` is ignored in this state.
- **Watchdog**
  - `wd_cnt` clears on every state entry and increments each cycle in GRANT or RESP.
  - When `TIMEOUT != 0` and `wd_cnt == TIMEOUT-1` with no qualifying event that cycle, go to IDLE and assert `timeout_err`.
  - A real ack or resp arriving in the same cycle wins over the timeout.
- **Every transition to IDLE**
  - Next cycle: `grant` = 0, `session_is_finished` = 1, `ptr` = (`owner`+1) mod `QTY_OF_DEVICES`.
  - `owner` keeps its value.
- **Fairness:** the last owner has lowest priority in the next arbitration. Every master with a persistent request is granted within `QTY_OF_DEVICES` sessions.
- **Widths:** `ptr` and `owner` are $clog2(QTY_OF_DEVICES) bits. Wrap-around is explicit modulo, so non-power-of-2 values of `QTY_OF_DEVICES` are legal. `wd_cnt` is $clog2(TIMEOUT+1) bits and saturates.

## Timing
- **Reset** (`rst_n` low at an edge):
  - Outputs: `grant` = 0, `owner` = 0, `busy` = 0, `session_is_finished` = 0, `timeout_err` = 0.
  - Internal: state = IDLE, `ptr` = 0, `wd_cnt` = 0.
  - Reset mid-session drops the grant with no finished pulse.
- **Latency**
  - `req` to `grant`: 1 cycle.
  - Write session minimum: grant at cycle 1, `slave_ack` at cycle 1, grant low and finish pulse at cycle 2.
  - Read session minimum: 3 cycles (ack at 1, resp at 2, finish at 3).
- **Back-to-back sessions**
  - In the finish-pulse cycle the FSM is in IDLE and arbitrates.
  - The next grant appears the cycle after the pulse, giving exactly one idle cycle between owners.
  - Commutation uses this cycle to switch the mux.
- **Input timing:** `cmd` is sampled only at the IDLE→GRANT edge. Later changes do not alter the session.
- **Output timing:** all outputs are registered; no combinational path from inputs to outputs.

## Structure
- Package `crossbar_pkg`:
  - `arb_state_t` enum {IDLE, GRANT, RESP}.
  - `CMD_READ` = 0, `CMD_WRITE` = 1.
  - Default `QTY_OF_DEVICES`.
- Sub-module `rr_priority_picker`:
  - Combinational.
  - Inputs: `req`, `ptr`. Outputs: winner index, `any_req`.
  - Implemented with double-width masked priority encode.
  - Reused by future arbiters.
- The FSM, counters and output registers live in `slave_session_arbiter`.

## Test plan
- **Reset:** `rst_n` = 0 for 2 cycles with `req` = 4'b1111, then release. Required: `grant` = 0 during reset, then 4'b0001 with `owner` = 0.
- **Write rotation:** `req` = 4'b1111, all `cmd` = 1, `slave_ack` held high. Required:
  - Grants in order 0001, 0010, 0100, 1000, 0001.
  - Each grant lasts 1 cycle, separated by one zero cycle carrying `session_is_finished`.
- **Read session:** master 2 only, `cmd[2]` = 0, ack 3 cycles after grant, resp 5 cycles after ack. Required:
  - `grant` = 4'b0100 throughout.
  - One finished pulse the cycle after resp, then `ptr` = 3.
- **Wrap and priority:** after master 3 finishes, `req` = 4'b1001. Required: master 0 wins next, then master 3.
- **Watchdog:** `TIMEOUT` = 8, read granted to master 1, ack given, resp never arrives. Required: grant drops and `session_is_finished` and `timeout_err` both pulse. Repeat with resp on cycle 7 of RESP: required normal finish, no `timeout_err`.
- **Abort and reset mid-session:**
  - Owner drops `req` in GRANT before ack. Required: finish pulse next cycle, no error.
  - Reset asserted in RESP. Required: grant 0 next edge, no pulse.
